// File: rtl/led_frame_writer_if.sv
// Pixel-stream and frame-memory read bus of the LED frame writer.
//   pix_valid/pix_ready/pix_sof/pix_data : raster RGB stream into the writer
//   mem_en/mem_buffer/mem_addr/mem_bit   : panel-driver read request
//   mem_dout                             : registered {R0,G0,B0,R1,G1,B1}
// master = stream source / panel driver side, slave = led_frame_writer.
interface led_frame_writer_if #(
  parameter int unsigned N_ROWS_MAX   = 64,
  parameter int unsigned N_COLS_MAX   = 256,
  parameter int unsigned BITDEPTH_MAX = 8
);
  localparam int unsigned R_MEM_ADDR_WIDTH = $clog2(N_ROWS_MAX * N_COLS_MAX) - 1;
  localparam int unsigned PLANE_W          = $clog2(BITDEPTH_MAX);
  localparam int unsigned PIX_W            = 3 * BITDEPTH_MAX;

  logic                        pix_valid;
  logic                        pix_ready;
  logic                        pix_sof;
  logic [PIX_W-1:0]            pix_data;
  logic                        mem_en;
  logic                        mem_buffer;
  logic [R_MEM_ADDR_WIDTH-1:0] mem_addr;
  logic [PLANE_W-1:0]          mem_bit;
  logic [5:0]                  mem_dout;

  modport master (
    output pix_valid, pix_sof, pix_data, mem_en, mem_buffer, mem_addr, mem_bit,
    input  pix_ready, mem_dout
  );

  modport slave (
    input  pix_valid, pix_sof, pix_data, mem_en, mem_buffer, mem_addr, mem_bit,
    output pix_ready, mem_dout
  );
endinterface

// File: rtl/led_frame_writer.sv
// LED frame writer: takes a raster RGB pixel stream and stores it as bit planes
// in a double-buffered frame memory read by the panel driver. The writer always
// fills the buffer the driver is not displaying.
// Ports:
//   clk, ctrl_rst_n (async active-low)
//   ctrl_en, ctrl_n_rows, ctrl_n_cols, ctrl_bitdepth : live configuration
//   frame_done  : one-cycle pulse after the last plane of the last pixel
//   err_tear    : sticky, driver buffer matched the buffer being written
//   err_sync    : sticky, sof seen mid-frame
//   bus         : pixel stream + memory read port (led_frame_writer_if.slave)
// Optional: define LED_FRAME_WRITER_GAMMA_EN for a gamma-2.2 lookup per channel.
module led_frame_writer #(
  parameter int unsigned N_ROWS_MAX   = 64,
  parameter int unsigned N_COLS_MAX   = 256,
  parameter int unsigned BITDEPTH_MAX = 8,
  parameter int unsigned CTRL_WIDTH   = 32
) (
  input  logic                  clk,
  input  logic                  ctrl_rst_n,
  input  logic                  ctrl_en,
  input  logic [CTRL_WIDTH-1:0] ctrl_n_rows,
  input  logic [CTRL_WIDTH-1:0] ctrl_n_cols,
  input  logic [CTRL_WIDTH-1:0] ctrl_bitdepth,
  output logic                  frame_done,
  output logic                  err_tear,
  output logic                  err_sync,
  led_frame_writer_if.slave     bus
);
  localparam int unsigned R_MEM_ADDR_WIDTH = $clog2(N_ROWS_MAX * N_COLS_MAX) - 1;
  localparam int unsigned ROW_W     = $clog2(N_ROWS_MAX);
  localparam int unsigned COL_W     = $clog2(N_COLS_MAX);
  localparam int unsigned PLANE_W   = $clog2(BITDEPTH_MAX);
  localparam int unsigned PIX_W     = 3 * BITDEPTH_MAX;
  localparam int unsigned IDX_W     = 1 + PLANE_W + R_MEM_ADDR_WIDTH;
  localparam int unsigned MEM_DEPTH = 2 ** IDX_W;

  typedef enum logic [1:0] {S_WAIT_SOF, S_READY, S_WRITE} state_t;

  state_t                  state_q, state_d;
  logic [ROW_W-1:0]        row_q;
  logic [COL_W-1:0]        col_q;
  logic [PLANE_W-1:0]      plane_q;
  logic                    wr_buf_q;
  logic [PIX_W-1:0]        pix_q;

  logic                    fire_c, sof_fire_c;
  logic                    last_plane_c, last_col_c, last_row_c;
  logic                    load_c, restart_c, wr_en_c, step_pix_c, done_c, sync_err_c, tear_c, ready_d;
  logic [CTRL_WIDTH-1:0]   row_ext_c, col_ext_c, plane_ext_c, half_rows_c, hrow_c;
  logic                    in_top_c;
  logic [R_MEM_ADDR_WIDTH-1:0] wr_addr_c;
  logic [IDX_W-1:0]        wr_idx_c, rd_idx_c;
  logic [PLANE_W-1:0]      bsel_c;
  logic [BITDEPTH_MAX-1:0] ch_r_c, ch_g_c, ch_b_c;
  logic [2:0]              wr_rgb_c;
  logic [PIX_W-1:0]        pix_map_c;

  logic [2:0] mem_top [MEM_DEPTH];
  logic [2:0] mem_bot [MEM_DEPTH];

  // Channel mapping applied when a pixel is accepted
`ifdef LED_FRAME_WRITER_GAMMA_EN
  localparam int unsigned LUT_N = 2 ** BITDEPTH_MAX;
  logic [BITDEPTH_MAX-1:0] gamma_rom [LUT_N];
  for (genvar gi = 0; gi < LUT_N; gi++) begin : g_gamma
    localparam real GX = real'(gi) / real'(LUT_N - 1);
    localparam int  GV = $rtoi((GX ** 2.2) * real'(LUT_N - 1) + 0.5);
    assign gamma_rom[gi] = BITDEPTH_MAX'(GV);
  end
  assign pix_map_c = {gamma_rom[bus.pix_data[3*BITDEPTH_MAX-1 -: BITDEPTH_MAX]],
                      gamma_rom[bus.pix_data[2*BITDEPTH_MAX-1 -: BITDEPTH_MAX]],
                      gamma_rom[bus.pix_data[BITDEPTH_MAX-1:0]]};
`else
  assign pix_map_c = bus.pix_data;
`endif

  // Position decode shared by the FSM and the write path
  always_comb begin
    fire_c       = bus.pix_valid & bus.pix_ready;
    sof_fire_c   = fire_c & bus.pix_sof;
    row_ext_c    = CTRL_WIDTH'(row_q);
    col_ext_c    = CTRL_WIDTH'(col_q);
    plane_ext_c  = CTRL_WIDTH'(plane_q);
    last_plane_c = (plane_ext_c == ctrl_bitdepth - CTRL_WIDTH'(1));
    last_col_c   = (col_ext_c == ctrl_n_cols - CTRL_WIDTH'(1));
    last_row_c   = (row_ext_c == ctrl_n_rows - CTRL_WIDTH'(1));
  end

  // State register
  always_ff @(posedge clk or negedge ctrl_rst_n) begin
    if (!ctrl_rst_n) state_q <= S_WAIT_SOF;
    else             state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (!ctrl_en) begin
      state_d = S_WAIT_SOF;
    end else begin
      case (state_q)
        S_WAIT_SOF: if (sof_fire_c) state_d = S_WRITE;
        S_READY:    if (fire_c)     state_d = S_WRITE;
        S_WRITE:    if (last_plane_c) state_d = (last_row_c && last_col_c) ? S_WAIT_SOF : S_READY;
        default:    state_d = S_WAIT_SOF;
      endcase
    end
  end

  // Output / control strobes
  always_comb begin
    load_c     = 1'b0;
    restart_c  = 1'b0;
    wr_en_c    = 1'b0;
    step_pix_c = 1'b0;
    done_c     = 1'b0;
    sync_err_c = 1'b0;
    ready_d    = ctrl_en && (state_d != S_WRITE);
    tear_c     = ctrl_en && (state_q != S_WAIT_SOF) && (bus.mem_buffer == wr_buf_q);
    if (ctrl_en) begin
      case (state_q)
        S_WAIT_SOF: if (sof_fire_c) begin
          load_c    = 1'b1;
          restart_c = 1'b1;
        end
        S_READY: if (fire_c) begin
          load_c = 1'b1;
          if (bus.pix_sof) begin
            restart_c  = 1'b1;
            sync_err_c = 1'b1;
          end
        end
        S_WRITE: begin
          wr_en_c = 1'b1;
          if (last_plane_c) begin
            step_pix_c = 1'b1;
            done_c     = last_row_c && last_col_c;
          end
        end
        default: ;
      endcase
    end
  end

  // Counters, pixel holding register and status flags
  always_ff @(posedge clk or negedge ctrl_rst_n) begin
    if (!ctrl_rst_n) begin
      row_q         <= '0;
      col_q         <= '0;
      plane_q       <= '0;
      wr_buf_q      <= 1'b0;
      pix_q         <= '0;
      bus.pix_ready <= 1'b0;
      frame_done    <= 1'b0;
      err_tear      <= 1'b0;
      err_sync      <= 1'b0;
    end else begin
      bus.pix_ready <= ready_d;
      frame_done    <= done_c;
      if (tear_c)     err_tear <= 1'b1;
      if (sync_err_c) err_sync <= 1'b1;
      if (load_c)     pix_q    <= pix_map_c;
      if (restart_c) begin
        row_q    <= '0;
        col_q    <= '0;
        wr_buf_q <= ~bus.mem_buffer;
      end
      if (load_c)       plane_q <= '0;
      else if (wr_en_c) plane_q <= last_plane_c ? '0 : plane_q + PLANE_W'(1);
      if (step_pix_c) begin
        if (last_col_c) begin
          col_q <= '0;
          row_q <= last_row_c ? '0 : row_q + ROW_W'(1);
        end else begin
          col_q <= col_q + COL_W'(1);
        end
      end
    end
  end

  // Write address/data: top half rows in mem_top, bottom half re-based into mem_bot
  always_comb begin
    half_rows_c = ctrl_n_rows >> 1;
    in_top_c    = (row_ext_c < half_rows_c);
    hrow_c      = in_top_c ? row_ext_c : row_ext_c - half_rows_c;
    wr_addr_c   = R_MEM_ADDR_WIDTH'(hrow_c * ctrl_n_cols + col_ext_c);
    wr_idx_c    = {wr_buf_q, plane_q, wr_addr_c};
    rd_idx_c    = {bus.mem_buffer, bus.mem_bit, bus.mem_addr};
    // Plane 0 is the lowest channel bit in use at the current bit depth
    bsel_c      = PLANE_W'(CTRL_WIDTH'(BITDEPTH_MAX) - ctrl_bitdepth + plane_ext_c);
    ch_r_c      = pix_q[3*BITDEPTH_MAX-1 -: BITDEPTH_MAX];
    ch_g_c      = pix_q[2*BITDEPTH_MAX-1 -: BITDEPTH_MAX];
    ch_b_c      = pix_q[BITDEPTH_MAX-1:0];
    wr_rgb_c    = {ch_r_c[bsel_c], ch_g_c[bsel_c], ch_b_c[bsel_c]};
  end

  // Frame memory, not cleared by reset
  always_ff @(posedge clk) begin
    if (wr_en_c) begin
      if (in_top_c) mem_top[wr_idx_c] <= wr_rgb_c;
      else          mem_bot[wr_idx_c] <= wr_rgb_c;
    end
  end

  // Registered read port, holds when not enabled
  always_ff @(posedge clk or negedge ctrl_rst_n) begin
    if (!ctrl_rst_n)     bus.mem_dout <= '0;
    else if (bus.mem_en) bus.mem_dout <= {mem_top[rd_idx_c], mem_bot[rd_idx_c]};
  end
endmodule

// File: tb/tb_led_frame_writer.sv
// Directed self-checking bench for led_frame_writer.
module tb_led_frame_writer;
  localparam int unsigned AW = $clog2(64 * 256) - 1;

  logic        clk = 1'b0;
  logic        ctrl_rst_n;
  logic        ctrl_en;
  logic [31:0] n_rows, n_cols, bitdepth;
  logic        frame_done, err_tear, err_sync;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int last_acc_cyc = 0;
  int first_acc = 0;
  int low_cnt = 0;

  led_frame_writer_if bus ();

  led_frame_writer dut (
    .clk          (clk),
    .ctrl_rst_n   (ctrl_rst_n),
    .ctrl_en      (ctrl_en),
    .ctrl_n_rows  (n_rows),
    .ctrl_n_cols  (n_cols),
    .ctrl_bitdepth(bitdepth),
    .frame_done   (frame_done),
    .err_tear     (err_tear),
    .err_sync     (err_sync),
    .bus          (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (frame_done === 1'b1) begin
    done_cnt = done_cnt + 1;
    done_cyc = cyc;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Present one pixel until accepted; counts cycles with pix_ready low
  task automatic send_pixel(input logic sof, input logic [23:0] d);
    logic rdy;
    bit   ok;
    ok = 0;
    low_cnt = 0;
    bus.pix_valid = 1'b1;
    bus.pix_sof   = sof;
    bus.pix_data  = d;
    for (int n = 0; n < 100 && !ok; n++) begin
      rdy = bus.pix_ready;
      if (!rdy) low_cnt++;
      @(posedge clk); #1;
      if (rdy) ok = 1;
    end
    bus.pix_valid = 1'b0;
    bus.pix_sof   = 1'b0;
    last_acc_cyc  = cyc - 1;
    if (!ok) begin
      checks++;
      failures++;
      $error("FAIL pix_accept observed=timeout expected=accept");
    end
  endtask

  task automatic send_frame(input int rows, input int cols, input logic [23:0] d);
    for (int i = 0; i < rows * cols; i++) begin
      send_pixel(i == 0, d);
      if (i == 0) first_acc = last_acc_cyc;
    end
  endtask

  task automatic wait_done(input int exp);
    for (int n = 0; n < 300 && done_cnt < exp; n++) begin
      @(posedge clk); #1;
    end
    check("done_cnt", 32'(done_cnt), 32'(exp));
  endtask

  task automatic read_mem(input logic b, input int pl, input int a, output logic [5:0] d);
    bus.mem_en     = 1'b1;
    bus.mem_buffer = b;
    bus.mem_bit    = 3'(pl);
    bus.mem_addr   = AW'(a);
    @(posedge clk); #1;
    d = bus.mem_dout;
    bus.mem_en     = 1'b0;
    bus.mem_buffer = 1'b0;
  endtask

  logic [5:0]  rd;
  logic [7:0]  gtop, gbot, gexp;
  logic [23:0] rowd [4];

  initial begin
    ctrl_rst_n = 1'b0;
    ctrl_en    = 1'b0;
    n_rows     = 32'd4;
    n_cols     = 32'd4;
    bitdepth   = 32'd8;
    bus.pix_valid  = 1'b0;
    bus.pix_sof    = 1'b0;
    bus.pix_data   = '0;
    bus.mem_en     = 1'b0;
    bus.mem_buffer = 1'b0;
    bus.mem_bit    = '0;
    bus.mem_addr   = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_pix_ready", 32'(bus.pix_ready), 0);
    check("rst_frame_done", 32'(frame_done), 0);
    check("rst_err_tear", 32'(err_tear), 0);
    check("rst_err_sync", 32'(err_sync), 0);
    check("rst_mem_dout", 32'(bus.mem_dout), 0);

    ctrl_rst_n = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    check("ready_en_low", 32'(bus.pix_ready), 0);
    ctrl_en = 1'b1;
    @(posedge clk); #1;
    check("ready_idle", 32'(bus.pix_ready), 1);

    // 4x4, 8 planes, R=A5 G=00 B=FF into buffer 1
    send_frame(4, 4, 24'hA5_00_FF);
    wait_done(1);
    check("t1_latency", 32'(done_cyc - first_acc), 32'd144);
    read_mem(1'b1, 0, 0, rd);  check("t1_p0_a0", 32'(rd), 32'b101101);
    read_mem(1'b1, 0, 7, rd);  check("t1_p0_a7", 32'(rd), 32'b101101);
    read_mem(1'b1, 1, 0, rd);  check("t1_p1_a0", 32'(rd), 32'b001001);
    read_mem(1'b1, 7, 5, rd);  check("t1_p7_a5", 32'(rd), 32'b101101);
    check("t1_err_tear", 32'(err_tear), 0);
    check("t1_err_sync", 32'(err_sync), 0);

    // 2x2, 4 planes, R=F0: planes map to channel bits 4..7
    n_rows = 32'd2; n_cols = 32'd2; bitdepth = 32'd4;
    send_pixel(1'b1, 24'hF0_00_00);
    send_pixel(1'b0, 24'hF0_00_00);
    check("t2_ready_low", 32'(low_cnt), 32'd4);
    send_pixel(1'b0, 24'hF0_00_00);
    send_pixel(1'b0, 24'hF0_00_00);
    wait_done(2);
    read_mem(1'b1, 0, 0, rd);  check("t2_p0_a0", 32'(rd), 32'b100100);
    read_mem(1'b1, 3, 1, rd);  check("t2_p3_a1", 32'(rd), 32'b100100);

    // Driver switches to the buffer being written mid-frame
    send_pixel(1'b1, 24'h11_22_33);
    bus.mem_buffer = 1'b1;
    send_pixel(1'b0, 24'h11_22_33);
    send_pixel(1'b0, 24'h11_22_33);
    send_pixel(1'b0, 24'h11_22_33);
    wait_done(3);
    check("t3_err_tear", 32'(err_tear), 1);
    bus.mem_buffer = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    check("t3_tear_sticky", 32'(err_tear), 1);
    check("t3_err_sync", 32'(err_sync), 0);

    // Three pixels, then a new sof restarts at row 0 / col 0
    n_rows = 32'd4; n_cols = 32'd4; bitdepth = 32'd4;
    rowd[0] = 24'hF0_00_00;
    rowd[1] = 24'h00_F0_00;
    rowd[2] = 24'h00_00_F0;
    rowd[3] = 24'hF0_F0_F0;
    send_pixel(1'b1, 24'h00_F0_F0);
    send_pixel(1'b0, 24'h00_F0_F0);
    send_pixel(1'b0, 24'h00_F0_F0);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        send_pixel(r == 0 && c == 0, rowd[r]);
    wait_done(4);
    check("t4_err_sync", 32'(err_sync), 1);
    read_mem(1'b1, 0, 0, rd);  check("t4_p0_a0", 32'(rd), 32'b100001);
    read_mem(1'b1, 0, 1, rd);  check("t4_p0_a1", 32'(rd), 32'b100001);
    read_mem(1'b1, 0, 4, rd);  check("t4_p0_a4", 32'(rd), 32'b010111);
    read_mem(1'b1, 3, 7, rd);  check("t4_p3_a7", 32'(rd), 32'b010111);

    // Asynchronous reset in the middle of a pixel write
    send_pixel(1'b1, 24'hFF_FF_FF);
    @(posedge clk); #3;
    ctrl_rst_n = 1'b0;
    #1;
    check("t5_pix_ready", 32'(bus.pix_ready), 0);
    check("t5_frame_done", 32'(frame_done), 0);
    check("t5_err_tear", 32'(err_tear), 0);
    check("t5_err_sync", 32'(err_sync), 0);
    check("t5_mem_dout", 32'(bus.mem_dout), 0);
    #2;
    ctrl_rst_n = 1'b1;
    @(posedge clk); #1;
    check("t5_ready_after", 32'(bus.pix_ready), 1);
    send_pixel(1'b0, 24'h12_34_56);
    check("t5_drop_ready", 32'(bus.pix_ready), 1);
    repeat (12) begin @(posedge clk); #1; end
    check("t5_no_done", 32'(done_cnt), 32'd4);

    // Mid-scale input at full bit depth
    n_rows = 32'd2; n_cols = 32'd2; bitdepth = 32'd8;
    send_frame(2, 2, 24'h80_00_00);
    wait_done(5);
    gtop = '0;
    gbot = '0;
    for (int p = 0; p < 8; p++) begin
      read_mem(1'b1, p, 0, rd);
      gtop[p] = rd[5];
      gbot[p] = rd[2];
    end
`ifdef LED_FRAME_WRITER_GAMMA_EN
    gexp = 8'h38;
`else
    gexp = 8'h80;
`endif
    check("t6_red_top", 32'(gtop), 32'(gexp));
    check("t6_red_bot", 32'(gbot), 32'(gexp));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
